// File: rtl/router_output_ctrl.sv
// router_output_ctrl
//   Output-port controller of a two-VC router. Two single-entry buffers hold
//   one packet each: buf 0 for the even VC, buf 1 for the odd VC. The
//   router-wide polarity picks which buffer accepts a packet from the input
//   controllers and which one is offered to the channel. The accept and send
//   buffers are always different, so an accept and a send can complete in the
//   same cycle.
//
//   Optional feature: define ROUTER_OUT_RR_EN for round-robin arbitration
//   between the two inputs. Without it, input 0 always wins a conflict.
//
// Ports
//   clk                      single clock, rising edge
//   rst                      synchronous active-high reset
//   polarity                 0: send even / accept odd, 1: send odd / accept even
//   in02out_req, in12out_req transfer requests from input controllers 0 / 1
//   out2in0_gnt, out2in1_gnt combinational grants back to the inputs
//   in02out_din, in12out_din packet data, sampled on the granted cycle
//   out2ch_vld               packet valid toward the channel
//   ch2out_rdy               channel ready
//   out2ch_dout              packet toward the channel, zero when not valid
module router_output_ctrl #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              polarity,
  input  logic              in02out_req,
  input  logic              in12out_req,
  output logic              out2in0_gnt,
  output logic              out2in1_gnt,
  input  logic [DATA_W-1:0] in02out_din,
  input  logic [DATA_W-1:0] in12out_din,
  output logic              out2ch_vld,
  input  logic              ch2out_rdy,
  output logic [DATA_W-1:0] out2ch_dout
);

  logic              acc_idx;
  logic              snd_idx;
  logic [DATA_W-1:0] buf_q [2];
  logic [1:0]        full_q;
  logic              win0;
  logic              gnt_any;
  logic              send;
  logic [DATA_W-1:0] wr_data;

  // Accept and send buffers are complementary by construction.
  assign acc_idx = ~polarity;
  assign snd_idx = polarity;

`ifdef ROUTER_OUT_RR_EN
  logic rr_ptr_q;  // 0: input 0 favoured, 1: input 1 favoured

  assign win0 = ~rr_ptr_q;

  // After a grant the pointer favours the input that was not served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (gnt_any) begin
      rr_ptr_q <= out2in0_gnt;
    end
  end
`else
  assign win0 = 1'b1;
`endif

  // A full accept buffer blocks both grants, even if it drains this cycle.
  always_comb begin
    out2in0_gnt = 1'b0;
    out2in1_gnt = 1'b0;
    if (!full_q[acc_idx]) begin
      if (in02out_req && (!in12out_req || win0)) begin
        out2in0_gnt = 1'b1;
      end else if (in12out_req) begin
        out2in1_gnt = 1'b1;
      end
    end
  end

  assign gnt_any = out2in0_gnt | out2in1_gnt;
  assign wr_data = out2in1_gnt ? in12out_din : in02out_din;

  assign out2ch_vld  = full_q[snd_idx];
  assign out2ch_dout = out2ch_vld ? buf_q[snd_idx] : '0;
  assign send        = out2ch_vld & ch2out_rdy;

  // Buffer write and channel send touch different entries, so both may
  // update full_q in the same cycle without conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q   <= 2'b00;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      if (gnt_any) begin
        buf_q[acc_idx]  <= wr_data;
        full_q[acc_idx] <= 1'b1;
      end
      if (send) begin
        full_q[snd_idx] <= 1'b0;
      end
    end
  end

endmodule
